// File: rtl/fp_mult_core_pkg.sv
// Shared constants, state encoding and operand classification for the
// single-precision multiply stage (fp_mult_core and its significand multiplier).
package fp_mult_core_pkg;

  localparam int WIDTH      = 32;                        // packed operand width
  localparam int EXP_WIDTH  = 8;                         // biased exponent width
  localparam int SIG_WIDTH  = WIDTH - EXP_WIDTH - 1;     // stored fraction width (23)
  localparam int BIAS       = 127;                       // exponent bias
  localparam int SIGW       = SIG_WIDTH + 1;             // significand incl. hidden bit
  localparam int PROD_WIDTH = 2 * SIGW;                  // full significand product
  localparam int ZEXP_WIDTH = EXP_WIDTH + 2;             // signed product exponent
  localparam int CNT_WIDTH  = $clog2(SIGW + 1);          // holds SIGW down to 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Classify one operand from its biased exponent and stored fraction.
  function automatic fp_class_t fp_classify(input logic [EXP_WIDTH-1:0] exp_f,
                                            input logic [SIG_WIDTH-1:0] frac);
    fp_class_t c;
    c.is_nan  = (&exp_f) && (|frac);
    c.is_inf  = (&exp_f) && !(|frac);
    c.is_zero = (exp_f == '0) && !(|frac);
    return c;
  endfunction

endpackage

// File: rtl/fp_sig_mul_seq.sv
// Iterative radix-2 shift-add significand multiplier, one partial product per
// cycle. A start pulse loads the operands and runs SIGW steps.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      load multiplicand/multiplier, clear accumulator, begin
//   mcand_i      multiplicand significand (SIGW bits)
//   mplier_i     multiplier significand (SIGW bits)
//   busy_o       steps remain
//   last_o       the current cycle performs the final step
//   prod_next_o  accumulator value after the current step; equals the full
//                product when last_o is high
module fp_sig_mul_seq
  import fp_mult_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [SIGW-1:0]       mcand_i,
  input  logic [SIGW-1:0]       mplier_i,
  output logic                  busy_o,
  output logic                  last_o,
  output logic [PROD_WIDTH-1:0] prod_next_o
);

  logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [PROD_WIDTH-1:0] acc_q,    acc_d;
  logic [SIGW-1:0]       mcand_q,  mcand_d;
  logic [SIGW-1:0]       mplier_q, mplier_d;

  logic [SIGW-1:0]       addend;
  logic [SIGW:0]         upper_sum;   // one extra bit catches the carry
  logic [PROD_WIDTH-1:0] acc_step;

  // The carry out of the upper-half add becomes the new MSB after the shift,
  // so no product bit is lost.
  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, acc_q[PROD_WIDTH-1:SIGW]} + {1'b0, addend};
    acc_step  = {upper_sum, acc_q[SIGW-1:1]};
  end

  assign busy_o      = (cnt_q != '0);
  assign last_o      = (cnt_q == CNT_WIDTH'(1));
  assign prod_next_o = acc_step;

  // NOTE: every always_comb output gets a hold default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      cnt_d    = CNT_WIDTH'(SIGW);
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
    end else if (busy_o) begin
      cnt_d    = cnt_q - CNT_WIDTH'(1);
      acc_d    = acc_step;
      mplier_d = mplier_q >> 1;
    end
  end

  // NOTE: the datapath registers are reset as well as the counter, so an
  // aborted operation leaves no residue in the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/fp_mult_core.sv
// Multicycle single-precision multiply stage. Classifies the unpacked operands,
// forms the product sign and unnormalized signed exponent, and drives the
// iterative significand multiplier. Special operands (NaN/Inf/Zero) resolve in
// one cycle; finite products take SIGW multiply cycles.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           operand handshake (ready only in IDLE)
//   aSign/bSign, aExp/bExp        operand signs and raw biased exponents
//   aSig/bSig                     significands with hidden bit resolved
//   aIsSubnormal/bIsSubnormal     subnormal flags from unpack
//   out_valid / out_ready         result handshake (valid only in DONE)
//   zSign, zExp, zSig             product sign, signed biased exponent,
//                                 raw product (binary point below bit 46)
//   zIsNaN, zIsInf, zIsZero       special-result flags
module fp_mult_core
  import fp_mult_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  aSign,
  input  logic                  bSign,
  input  logic [EXP_WIDTH-1:0]  aExp,
  input  logic [EXP_WIDTH-1:0]  bExp,
  input  logic [SIGW-1:0]       aSig,
  input  logic [SIGW-1:0]       bSig,
  input  logic                  aIsSubnormal,
  input  logic                  bIsSubnormal,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  zSign,
  output logic [ZEXP_WIDTH-1:0] zExp,
  output logic [PROD_WIDTH-1:0] zSig,
  output logic                  zIsNaN,
  output logic                  zIsInf,
  output logic                  zIsZero
);

  state_e state_q, state_d;

  logic                  z_sign_q;
  logic [ZEXP_WIDTH-1:0] z_exp_q;
  logic [PROD_WIDTH-1:0] z_sig_q;
  logic                  z_nan_q, z_inf_q, z_zero_q;

  fp_class_t             a_cls, b_cls;
  logic                  special, res_nan, res_inf, res_zero;
  logic                  accept;
  logic [ZEXP_WIDTH-1:0] a_eff_exp, b_eff_exp, exp_sum;

  logic                  sig_busy, sig_last, sig_done;
  logic [PROD_WIDTH-1:0] sig_prod_next;

  // A zero exponent already identifies a subnormal, so the unpack flags
  // carry no extra information here.
  logic unused_sub;
  assign unused_sub = aIsSubnormal ^ bIsSubnormal;

  assign a_cls = fp_classify(aExp, aSig[SIG_WIDTH-1:0]);
  assign b_cls = fp_classify(bExp, bSig[SIG_WIDTH-1:0]);

  assign special  = (|a_cls) || (|b_cls);
  assign res_nan  = a_cls.is_nan || b_cls.is_nan
                 || (a_cls.is_inf && b_cls.is_zero)
                 || (a_cls.is_zero && b_cls.is_inf);
  assign res_inf  = !res_nan && (a_cls.is_inf || b_cls.is_inf);
  assign res_zero = special && !res_nan && !res_inf;

  // Subnormals use exponent 1; the sum fits in ZEXP_WIDTH signed bits
  // (-125..381), so plain modular arithmetic gives the two's complement result.
  assign a_eff_exp = (aExp == '0) ? ZEXP_WIDTH'(1) : ZEXP_WIDTH'(aExp);
  assign b_eff_exp = (bExp == '0) ? ZEXP_WIDTH'(1) : ZEXP_WIDTH'(bExp);
  assign exp_sum   = a_eff_exp + b_eff_exp - ZEXP_WIDTH'(BIAS);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready && in_valid;
  assign sig_done  = sig_busy && sig_last;

  fp_sig_mul_seq u_sig_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (accept && !special),
    .mcand_i     (aSig),
    .mplier_i    (bSig),
    .busy_o      (sig_busy),
    .last_o      (sig_last),
    .prod_next_o (sig_prod_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = special ? DONE : MUL;
      MUL:  if (sig_done) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Result fields move only on the accept edge and the final multiply step,
  // so they stay stable for the whole DONE stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_sign_q <= 1'b0;
      z_exp_q  <= '0;
      z_sig_q  <= '0;
      z_nan_q  <= 1'b0;
      z_inf_q  <= 1'b0;
      z_zero_q <= 1'b0;
    end else if (accept) begin
      z_sign_q <= aSign ^ bSign;
      z_exp_q  <= special ? '0 : exp_sum;
      z_sig_q  <= '0;
      z_nan_q  <= res_nan;
      z_inf_q  <= res_inf;
      z_zero_q <= res_zero;
    end else if (sig_done) begin
      z_sig_q  <= sig_prod_next;
    end
  end

  assign zSign   = z_sign_q;
  assign zExp    = z_exp_q;
  assign zSig    = z_sig_q;
  assign zIsNaN  = z_nan_q;
  assign zIsInf  = z_inf_q;
  assign zIsZero = z_zero_q;

endmodule

// File: tb/tb_fp_mult_core.sv
// Self-checking bench for fp_mult_core: directed cases, backpressure, reset
// abort, randomized operands against a plain-arithmetic reference model, and
// back-to-back issue with in_valid held high.
module tb_fp_mult_core;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        sub;
  } operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } op_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] sig;
    logic        nan;
    logic        inf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic        aSign = 1'b0, bSign = 1'b0;
  logic [7:0]  aExp = '0, bExp = '0;
  logic [23:0] aSig = '0, bSig = '0;
  logic        aIsSubnormal = 1'b0, bIsSubnormal = 1'b0;
  logic        zSign, zIsNaN, zIsInf, zIsZero;
  logic [9:0]  zExp;
  logic [47:0] zSig;
  res_t        obs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_mult_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .aSign        (aSign),
    .bSign        (bSign),
    .aExp         (aExp),
    .bExp         (bExp),
    .aSig         (aSig),
    .bSig         (bSig),
    .aIsSubnormal (aIsSubnormal),
    .bIsSubnormal (bIsSubnormal),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .zSign        (zSign),
    .zExp         (zExp),
    .zSig         (zSig),
    .zIsNaN       (zIsNaN),
    .zIsInf       (zIsInf),
    .zIsZero      (zIsZero)
  );

  assign obs = {zSign, zExp, zSig, zIsNaN, zIsInf, zIsZero};

  // Reference: IEEE classification rules, integer exponent arithmetic and a
  // direct 64-bit multiply of the significands.
  function automatic res_t model(input op_t op);
    res_t   r;
    logic   a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    int     ea, eb, e;
    longint p;
    r      = '0;
    r.sign = op.a.sign ^ op.b.sign;
    a_nan  = (op.a.exp == 8'd255) && (op.a.sig[22:0] != 0);
    a_inf  = (op.a.exp == 8'd255) && (op.a.sig[22:0] == 0);
    a_zero = (op.a.exp == 8'd0)   && (op.a.sig[22:0] == 0);
    b_nan  = (op.b.exp == 8'd255) && (op.b.sig[22:0] != 0);
    b_inf  = (op.b.exp == 8'd255) && (op.b.sig[22:0] == 0);
    b_zero = (op.b.exp == 8'd0)   && (op.b.sig[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) r.nan = 1'b1;
    else if (a_inf || b_inf) r.inf = 1'b1;
    else if (a_zero || b_zero) r.zero = 1'b1;
    else begin
      ea    = (op.a.exp == 0) ? 1 : int'(op.a.exp);
      eb    = (op.b.exp == 0) ? 1 : int'(op.b.exp);
      e     = ea + eb - 127;
      r.exp = 10'(e);
      p     = longint'(op.a.sig) * longint'(op.b.sig);
      r.sig = 48'(p);
    end
    return r;
  endfunction

  function automatic operand_t rand_operand(input bit normal_only);
    operand_t o;
    int kind;
    kind   = normal_only ? 0 : int'($urandom_range(0, 9));
    o.sign = 1'($urandom_range(0, 1));
    o.sub  = 1'b0;
    case (kind)
      6: begin o.exp = 8'd0;   o.sig = 24'($urandom_range(1, 23'h7FFFFF)); o.sub = 1'b1; end
      7: begin o.exp = 8'd0;   o.sig = 24'h000000; end
      8: begin o.exp = 8'd255; o.sig = 24'h800000; end
      9: begin o.exp = 8'd255; o.sig = 24'h800000 | 24'($urandom_range(1, 23'h7FFFFF)); end
      default: begin o.exp = 8'($urandom_range(1, 254)); o.sig = {1'b1, 23'($urandom)}; end
    endcase
    return o;
  endfunction

  task automatic apply(input op_t op);
    aSign = op.a.sign; aExp = op.a.exp; aSig = op.a.sig; aIsSubnormal = op.a.sub;
    bSign = op.b.sign; bExp = op.b.exp; bSig = op.b.sig; bIsSubnormal = op.b.sub;
  endtask

  // Issue one operation, wait (bounded) for out_valid, stall `hold` cycles,
  // then complete the result handshake. Runs at posedge+1.
  task automatic run_op(input op_t op, input int hold, output res_t got,
                        output logic vld, output int lat);
    apply(op);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (hold) begin @(posedge clk); #1; end
    got = obs;
    vld = out_valid;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (obs !== res_t'(0)) $display("FAIL reset outputs: got %h expected 0", obs); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL post-reset idle: got ready/valid %b expected 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_directed();
    op_t  ops[6];
    res_t exps[6];
    int   lats[6];
    res_t got;
    logic vld;
    int   lat;
    ops[0] = {1'b0, 8'd127, 24'hC00000, 1'b0, 1'b0, 8'd128, 24'h800000, 1'b0};
    exps[0] = {1'b0, 10'd128, 48'h6000_0000_0000, 3'b000}; lats[0] = 24;
    ops[1] = {1'b0, 8'd255, 24'h800000, 1'b0, 1'b0, 8'd0, 24'h000000, 1'b0};
    exps[1] = {1'b0, 10'd0, 48'h0, 3'b100}; lats[1] = 0;
    ops[2] = {1'b1, 8'd255, 24'h800000, 1'b0, 1'b0, 8'd128, 24'h800000, 1'b0};
    exps[2] = {1'b1, 10'd0, 48'h0, 3'b010}; lats[2] = 0;
    ops[3] = {1'b0, 8'd0, 24'h000001, 1'b1, 1'b0, 8'd127, 24'h800000, 1'b0};
    exps[3] = {1'b0, 10'd1, 48'h0000_0080_0000, 3'b000}; lats[3] = 24;
    ops[4] = {1'b1, 8'd0, 24'h000000, 1'b0, 1'b0, 8'd130, 24'hA00000, 1'b0};
    exps[4] = {1'b1, 10'd0, 48'h0, 3'b001}; lats[4] = 0;
    ops[5] = {1'b0, 8'd255, 24'h800001, 1'b0, 1'b1, 8'd0, 24'h000000, 1'b0};
    exps[5] = {1'b1, 10'd0, 48'h0, 3'b100}; lats[5] = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 0, got, vld, lat);
      n_checks++;
      if (lat !== lats[i]) $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, lats[i]);
      else n_pass++;
      n_checks++;
      if ({vld, got} !== {1'b1, exps[i]})
        $display("FAIL directed[%0d] result: got %b/%h expected 1/%h", i, vld, got, exps[i]);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL directed[%0d] idle after handshake: got in_ready %b expected 1", i, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    op_t  op;
    res_t exp_r;
    int   lat;
    op    = {1'b0, 8'd127, 24'hC00000, 1'b0, 1'b0, 8'd128, 24'h800000, 1'b0};
    exp_r = {1'b0, 10'd128, 48'h6000_0000_0000, 3'b000};
    apply(op);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== 24) $display("FAIL backpressure latency: got %0d expected 24", lat); else n_pass++;
    // Offer a different operation while the result is stalled.
    apply({1'b1, 8'd128, 24'hC00000, 1'b0, 1'b0, 8'd128, 24'hC00000, 1'b0});
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, exp_r})
        $display("FAIL backpressure stall[%0d]: got %b%b/%h expected 10/%h", i, out_valid, in_ready, obs, exp_r);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL backpressure release: got ready/valid %b expected 10", {in_ready, out_valid});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL backpressure no ghost accept: got ready/valid %b expected 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    res_t got;
    logic vld;
    int   lat;
    apply({1'b0, 8'd140, 24'hFFFFFF, 1'b0, 1'b1, 8'd100, 24'hABCDEF, 1'b0});
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL abort handshake: got valid/ready %b expected 01", {out_valid, in_ready});
    else n_pass++;
    n_checks++;
    if (obs !== res_t'(0)) $display("FAIL abort outputs: got %h expected 0", obs); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op({1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0, 8'd128, 24'hC00000, 1'b0}, 0, got, vld, lat);
    n_checks++;
    if (lat !== 24) $display("FAIL post-abort latency: got %0d expected 24", lat); else n_pass++;
    n_checks++;
    if ({vld, got} !== {1'b1, 1'b0, 10'd129, 48'h9000_0000_0000, 3'b000})
      $display("FAIL post-abort 3x3: got %b/%h expected 1/%h", vld, got,
               {1'b0, 10'd129, 48'h9000_0000_0000, 3'b000});
    else n_pass++;
  endtask

  task automatic test_random();
    op_t  op;
    res_t exp_r, got;
    logic vld;
    int   lat, exp_lat;
    for (int i = 0; i < 20; i++) begin
      op      = {rand_operand(1'b0), rand_operand(1'b0)};
      exp_r   = model(op);
      exp_lat = (exp_r.nan || exp_r.inf || exp_r.zero) ? 0 : 24;
      run_op(op, int'($urandom_range(0, 3)), got, vld, lat);
      n_checks++;
      if (lat !== exp_lat) $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, exp_lat);
      else n_pass++;
      n_checks++;
      if ({vld, got} !== {1'b1, exp_r})
        $display("FAIL random[%0d] result op=%h: got %b/%h expected 1/%h", i, op, vld, got, exp_r);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL random[%0d] idle after handshake: got %b expected 1", i, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    op_t  ops[5];
    res_t exp_r;
    int   idx, accepts, results;
    logic acc_now, hs_now;
    for (int i = 0; i < 5; i++) ops[i] = {rand_operand(1'b1), rand_operand(1'b1)};
    idx = 0; accepts = 0; results = 0;
    out_ready = 1'b1;
    apply(ops[0]);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && results < 5; cyc++) begin
      acc_now = in_valid && in_ready;
      hs_now  = out_valid && out_ready;
      if (hs_now) begin
        exp_r = model(ops[results]);
        n_checks++;
        if (obs !== exp_r) $display("FAIL b2b[%0d] result: got %h expected %h", results, obs, exp_r);
        else n_pass++;
        n_checks++;
        if (accepts !== results + 1)
          $display("FAIL b2b[%0d] accepts per handshake: got %0d expected %0d", results, accepts, results + 1);
        else n_pass++;
        results++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        accepts++;
        idx++;
        if (idx < 5) apply(ops[idx]);
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (results !== 5) $display("FAIL b2b results: got %0d expected 5", results); else n_pass++;
    n_checks++;
    if (accepts !== 5) $display("FAIL b2b accepts: got %0d expected 5", accepts); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
